arm_pipelined_fetch_stage: RTL and testbench

//  IF stage + IF/ID register of the 5-stage ARM pipeline. Owns the fetch PC, issues word requests to a

---
 rtl/arm_pipelined_pkg.sv | 12 +
 rtl/arm_fetch_ctrl.sv | 93 +++++++++
 rtl/arm_pipelined_fetch_stage.sv | 106 ++++++++++
 tb/tb_arm_pipelined_fetch_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipelined_pkg.sv
// Shared types and constants for the ARM pipeline fetch stage.
package arm_pipelined_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    localparam logic [31:0] ARM_NOP = 32'hE1A00000;

endpackage

// File: rtl/arm_fetch_ctrl.sv
// Fetch FSM: tracks the outstanding request and chooses the next PC and the IF/ID load source.
module arm_fetch_ctrl
    import arm_pipelined_pkg::*;
#(
    parameter int BusWidth = 32
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                ack,
    input  logic                hold_req,
    input  logic                redir,
    input  logic [BusWidth-1:0] target,
    input  logic [BusWidth-1:0] pcf,
    output fetch_state_t        state,
    output logic                pc_en,
    output logic [BusWidth-1:0] pc_next,
    output logic                load_mem,
    output logic                load_hold,
    output logic                capture_hold
);

    // Target remembered while a request issued before a redirect is still in flight.
    logic [BusWidth-1:0] redir_pc;

    always_comb begin
        pc_en        = 1'b0;
        pc_next      = pcf + BusWidth'(4);
        load_mem     = 1'b0;
        load_hold    = 1'b0;
        capture_hold = 1'b0;
        case (state)
            FETCH: begin
                if (ack) begin
                    pc_en = 1'b1;
                    if (redir) begin
                        pc_next = target;
                    end else if (hold_req) begin
                        capture_hold = 1'b1;
                    end else begin
                        load_mem = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (ack) begin
                    pc_en   = 1'b1;
                    pc_next = redir ? target : redir_pc;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_en   = 1'b1;
                    pc_next = target;
                end else if (!hold_req) begin
                    load_hold = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state    <= FETCH;
            redir_pc <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (ack && !redir && hold_req) begin
                        state <= HOLD;
                    end else if (!ack && redir) begin
                        redir_pc <= target;
                        state    <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        state <= FETCH;
                    end else if (redir) begin
                        redir_pc <= target;
                    end
                end
                HOLD: begin
                    if (redir || !hold_req) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: rtl/arm_pipelined_fetch_stage.sv
// IF stage plus IF/ID register: fetch PC, hold buffer for stalled acks, and decode-side outputs.
module arm_pipelined_fetch_stage
    import arm_pipelined_pkg::*;
#(
    parameter int                  BusWidth    = 32,
    parameter logic [BusWidth-1:0] ResetVector = '0
) (
    input  logic                i_CLK,
    input  logic                i_NRESET,
    output logic                o_IMEM_Req,
    output logic [BusWidth-1:0] o_IMEM_Addr,
    input  logic                i_IMEM_Ack,
    input  logic [BusWidth-1:0] i_IMEM_RData,
    input  logic                i_StallD,
    input  logic                i_FlushD,
    input  logic                i_BranchTakenE,
    input  logic [BusWidth-1:0] i_BranchTargetE,
    input  logic                i_PCSrcW,
    input  logic [BusWidth-1:0] i_ResultW,
    output logic [BusWidth-1:0] o_InstrD,
    output logic [BusWidth-1:0] o_PCPlus8D,
    output logic                o_ValidD
);

    localparam logic [BusWidth-1:0] ALIGN_MASK = ~BusWidth'(3);

    logic                redir;
    logic [BusWidth-1:0] target;
    logic [BusWidth-1:0] pcf;
    logic [BusWidth-1:0] pc_next;
    logic [BusWidth-1:0] hold_instr;
    logic [BusWidth-1:0] hold_pc;
    logic                pc_en;
    logic                load_mem;
    logic                load_hold;
    logic                capture_hold;
    fetch_state_t        state;

    always_comb begin
        redir  = i_BranchTakenE | i_PCSrcW;
        target = i_BranchTakenE ? i_BranchTargetE : i_ResultW;
    end

    // A flush must not lose a returning fetch, so it parks the ack in HOLD like a stall.
    arm_fetch_ctrl #(
        .BusWidth (BusWidth)
    ) u_ctrl (
        .clk          (i_CLK),
        .nreset       (i_NRESET),
        .ack          (i_IMEM_Ack),
        .hold_req     (i_StallD | i_FlushD),
        .redir        (redir),
        .target       (target),
        .pcf          (pcf),
        .state        (state),
        .pc_en        (pc_en),
        .pc_next      (pc_next),
        .load_mem     (load_mem),
        .load_hold    (load_hold),
        .capture_hold (capture_hold)
    );

    assign o_IMEM_Req  = (state != HOLD);
    assign o_IMEM_Addr = pcf;

    always_ff @(posedge i_CLK) begin
        if (!i_NRESET) begin
            pcf <= ResetVector & ALIGN_MASK;
        end else if (pc_en) begin
            pcf <= pc_next & ALIGN_MASK;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_NRESET) begin
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (capture_hold) begin
            hold_instr <= i_IMEM_RData;
            hold_pc    <= pcf;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_NRESET || i_FlushD) begin
            o_InstrD   <= '0;
            o_PCPlus8D <= '0;
            o_ValidD   <= 1'b0;
        end else if (!i_StallD) begin
            if (load_mem) begin
                o_InstrD   <= i_IMEM_RData;
                o_PCPlus8D <= pcf + BusWidth'(8);
                o_ValidD   <= 1'b1;
            end else if (load_hold) begin
                o_InstrD   <= hold_instr;
                o_PCPlus8D <= hold_pc + BusWidth'(8);
                o_ValidD   <= 1'b1;
            end else begin
                o_InstrD   <= '0;
                o_PCPlus8D <= '0;
                o_ValidD   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arm_pipelined_fetch_stage.sv
// Bench for the fetch stage: directed scenarios then random traffic against an in-order delivery model.
module tb_arm_pipelined_fetch_stage;
    import arm_pipelined_pkg::*;

    logic        clk = 1'b0;
    logic        i_NRESET;
    logic        o_IMEM_Req;
    logic [31:0] o_IMEM_Addr;
    logic        i_IMEM_Ack;
    logic [31:0] i_IMEM_RData;
    logic        i_StallD;
    logic        i_FlushD;
    logic        i_BranchTakenE;
    logic [31:0] i_BranchTargetE;
    logic        i_PCSrcW;
    logic [31:0] i_ResultW;
    logic [31:0] o_InstrD;
    logic [31:0] o_PCPlus8D;
    logic        o_ValidD;

    always #5 clk = ~clk;

    arm_pipelined_fetch_stage #(
        .BusWidth    (32),
        .ResetVector (32'h0)
    ) dut (
        .i_CLK           (clk),
        .i_NRESET        (i_NRESET),
        .o_IMEM_Req      (o_IMEM_Req),
        .o_IMEM_Addr     (o_IMEM_Addr),
        .i_IMEM_Ack      (i_IMEM_Ack),
        .i_IMEM_RData    (i_IMEM_RData),
        .i_StallD        (i_StallD),
        .i_FlushD        (i_FlushD),
        .i_BranchTakenE  (i_BranchTakenE),
        .i_BranchTargetE (i_BranchTargetE),
        .i_PCSrcW        (i_PCSrcW),
        .i_ResultW       (i_ResultW),
        .o_InstrD        (o_InstrD),
        .o_PCPlus8D      (o_PCPlus8D),
        .o_ValidD        (o_ValidD)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: addresses accepted from memory but not yet in decode, in program order.
    logic [31:0] exp_q[$];
    logic        outstanding;
    logic        killed;
    logic [31:0] req_addr;
    logic [31:0] model_pc;
    logic        md_valid;
    logic [31:0] md_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ ARM_NOP;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        outstanding = 1'b0;
        killed      = 1'b0;
        req_addr    = 32'h0;
        model_pc    = 32'h0;
        md_valid    = 1'b0;
        md_addr     = 32'h0;
    endtask

    task automatic drive_idle();
        i_IMEM_Ack      = 1'b0;
        i_IMEM_RData    = 32'h0;
        i_StallD        = 1'b0;
        i_FlushD        = 1'b0;
        i_BranchTakenE  = 1'b0;
        i_BranchTargetE = 32'h0;
        i_PCSrcW        = 1'b0;
        i_ResultW       = 32'h0;
    endtask

    // Called at a negedge; an ack during reset must be ignored.
    task automatic do_reset(input bit ack_in);
        drive_idle();
        i_NRESET     = 1'b0;
        i_IMEM_Ack   = ack_in;
        i_IMEM_RData = $urandom;
        i_StallD     = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_valid", 32'(o_ValidD), 32'h0);
        chk("rst_instr", o_InstrD, 32'h0);
        chk("rst_pc8", o_PCPlus8D, 32'h0);
        chk("rst_addr", o_IMEM_Addr, 32'h0);
        chk("rst_req", 32'(o_IMEM_Req), 32'h1);
        drive_idle();
        i_NRESET = 1'b1;
    endtask

    // One clock: apply inputs at negedge, advance the model, check IF/ID at the next negedge.
    task automatic step(input bit a, input bit st, input bit fl,
                        input bit br, input logic [31:0] bt,
                        input bit pw, input logic [31:0] rw);
        bit          ack_v;
        bit          redir;
        logic [31:0] tgt;
        chk("req", 32'(o_IMEM_Req), 32'(exp_q.size() == 0));
        ack_v = 1'b0;
        if (o_IMEM_Req) begin
            if (!outstanding) begin
                outstanding = 1'b1;
                killed      = 1'b0;
                chk("addr", o_IMEM_Addr, model_pc);
                req_addr = model_pc;
            end else begin
                chk("addr_stable", o_IMEM_Addr, req_addr);
            end
            ack_v = a;
        end
        i_IMEM_Ack      = ack_v;
        i_IMEM_RData    = instr_of(req_addr);
        i_StallD        = st;
        i_FlushD        = fl;
        i_BranchTakenE  = br;
        i_BranchTargetE = bt;
        i_PCSrcW        = pw;
        i_ResultW       = rw;

        redir = br | pw;
        tgt   = br ? bt : rw;
        if (ack_v) begin
            outstanding = 1'b0;
            if (!killed && !redir) begin
                exp_q.push_back(req_addr);
                model_pc = req_addr + 32'd4;
            end
        end
        if (redir) begin
            exp_q.delete();
            model_pc = tgt & ~32'h3;
            if (outstanding) killed = 1'b1;
        end
        if (fl) begin
            md_valid = 1'b0;
        end else if (!st) begin
            if (exp_q.size() > 0) begin
                md_addr  = exp_q.pop_front();
                md_valid = 1'b1;
            end else begin
                md_valid = 1'b0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk("validd", 32'(o_ValidD), 32'(md_valid));
        if (md_valid) begin
            chk("instrd", o_InstrD, instr_of(md_addr));
            chk("pc8d", o_PCPlus8D, md_addr + 32'd8);
        end else begin
            chk("instrd_zero", o_InstrD, 32'h0);
        end
    endtask

    task automatic idle(input bit a);
        step(a, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        drive_idle();
        i_NRESET = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(1'b1);

        for (int i = 0; i < 3; i++) idle(1'b1);
        for (int i = 0; i < 3; i++) idle(1'b0);
        idle(1'b1);

        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0);
        idle(1'b1);

        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300);
        idle(1'b1);
        idle(1'b1);

        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        idle(1'b0);
        do_reset(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0);
        idle(1'b1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                step(($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 11) == 0), $urandom,
                     ($urandom_range(0, 11) == 0), $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
